// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared types and constants for the CPU pipeline stages
package cpu_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int WB_DATA_W  = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } mem_state_t;

  typedef struct packed {
    logic                  wen;
    logic                  fp;
    logic [REG_ADDR_W-1:0] rd;
    logic [WB_DATA_W-1:0]  data;
  } wb_pkt_t;

  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage.sv
// rtl/mem_access_stage.sv - memory-access stage: word load/store on req/gnt/rvalid port, registered writeback
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [DATA_W-1:0]     ex_aluresult,
  input  logic [DATA_W-1:0]     ex_store_data,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_wen,
  input  logic                  ex_fp,
  input  logic                  ex_load,
  input  logic                  ex_store,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_W-1:0]     dmem_addr,
  output logic [DATA_W-1:0]     dmem_wdata,
  input  logic                  dmem_gnt,
  input  logic                  dmem_rvalid,
  input  logic [DATA_W-1:0]     dmem_rdata,
  output logic                  wb_valid,
  output logic                  wb_wen,
  output logic                  wb_fp,
  output logic [REG_ADDR_W-1:0] wb_rd,
  output logic [DATA_W-1:0]     wb_data,
  output logic                  misalign
);

  mem_state_t state_q, state_d;

  logic              req_q, req_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  wb_pkt_t           lat_q, lat_d;
  wb_pkt_t           wb_q, wb_d;
  logic              wb_valid_q, wb_valid_d;
  logic              misalign_q, misalign_d;

  always_comb begin
    state_d    = state_q;
    req_d      = 1'b0;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    lat_d      = lat_q;
    wb_d       = wb_q;
    wb_valid_d = 1'b0;
    misalign_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (ex_valid) begin
          if (ex_load || ex_store) begin
            if (is_misaligned(ex_aluresult[1:0])) begin
              wb_valid_d = 1'b1;
              misalign_d = 1'b1;
              wb_d       = '{wen: 1'b0, fp: ex_fp, rd: ex_rd, data: ex_aluresult};
            end else begin
              state_d = REQ;
              req_d   = 1'b1;
              // A combined load+store request resolves to a load
              we_d    = ex_store & ~ex_load;
              addr_d  = ex_aluresult[ADDR_W-1:0];
              wdata_d = ex_store_data;
              lat_d   = '{wen: ex_wen, fp: ex_fp, rd: ex_rd, data: ex_aluresult};
            end
          end else begin
            wb_valid_d = 1'b1;
            wb_d       = '{wen: ex_wen, fp: ex_fp, rd: ex_rd, data: ex_aluresult};
          end
        end
      end

      REQ: begin
        if (dmem_gnt) begin
          if (we_q) begin
            state_d    = IDLE;
            wb_valid_d = 1'b1;
            wb_d       = '{wen: 1'b0, fp: lat_q.fp, rd: lat_q.rd, data: lat_q.data};
          end else begin
            state_d = WAIT;
          end
        end else begin
          req_d = 1'b1;
        end
      end

      WAIT: begin
        if (dmem_rvalid) begin
          state_d    = IDLE;
          wb_valid_d = 1'b1;
          wb_d       = '{wen: lat_q.wen, fp: lat_q.fp, rd: lat_q.rd, data: dmem_rdata};
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      state_q    <= IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      lat_q      <= '0;
      wb_q       <= '0;
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      lat_q      <= lat_d;
      wb_q       <= wb_d;
      wb_valid_q <= wb_valid_d;
      misalign_q <= misalign_d;
    end
  end

  assign ex_ready   = (state_q == IDLE);
  assign dmem_req   = req_q;
  assign dmem_we    = we_q;
  assign dmem_addr  = addr_q;
  assign dmem_wdata = wdata_q;
  assign wb_valid   = wb_valid_q;
  assign wb_wen     = wb_q.wen;
  assign wb_fp      = wb_q.fp;
  assign wb_rd      = wb_q.rd;
  assign wb_data    = wb_q.data;
  assign misalign   = misalign_q;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-access pipeline stage directly downstream of the ALU. Takes the ALU result (effective address for lw/sw/flw/fsw, or plain result otherwise), performs word loads/stores on a req/gnt/rvalid data-memory port, stalls the ALU stage via a valid/ready handshake while memory is busy, and delivers a registered writeback packet to the integer or FP register file.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width
- DATA_W, 32, data word width

Ports:
- clk  in  1  clock; all logic on rising edge
- rstn  in  1  synchronous, active-high reset (asserted = 1)
- ex_valid  in  1  ALU stage presents an instruction
- ex_ready  out  1  stage accepts this cycle
- ex_aluresult  in  32  ALU result / effective address
- ex_store_data  in  32  store data (int or FP source, selected upstream)
- ex_rd  in  5  destination register
- ex_wen  in  1  instruction writes a register
- ex_fp  in  1  destination is FP register file (flw, fmv.w.x)
- ex_load  in  1  lw/flw
- ex_store  in  1  sw/fsw
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned byte address
- dmem_wdata  out  32  write data
- dmem_gnt  in  1  request accepted this cycle
- dmem_rvalid  in  1  read data valid
- dmem_rdata  in  32  read data
- wb_valid  out  1  writeback packet valid (one-cycle pulse)
- wb_wen  out  1  register write enable
- wb_fp  out  1  FP register file select
- wb_rd  out  5  destination register
- wb_data  out  32  writeback data
- misalign  out  1  pulse: accepted load/store with addr[1:0] != 0

## Operation
- States: IDLE, REQ, WAIT. ex_ready = (state == IDLE). Accept = ex_valid & ex_ready.
- Accept non-memory op: next cycle wb_valid=1, wb_data=ex_aluresult, wb_wen/wb_fp/wb_rd copied; stay IDLE.
- Accept load/store with addr[1:0] == 0: latch addr, data, rd, wen, fp, kind; go REQ.
- Accept load/store with addr[1:0] != 0: no memory request; next cycle misalign=1, wb_valid=1, wb_wen=0; stay IDLE.
- ex_load and ex_store both set: treated as load.
- REQ: dmem_req=1, dmem_we=store, addr/wdata from latches, held stable until dmem_gnt. On gnt: store → wb_valid=1, wb_wen=0 next cycle, go IDLE; load → WAIT.
- WAIT: dmem_req=0. On dmem_rvalid: next cycle wb_valid=1, wb_data=dmem_rdata, wb_wen=latched wen, wb_fp/wb_rd latched; go IDLE.
- dmem_rvalid outside WAIT is ignored (covers responses to transactions abandoned by reset).
- Only one outstanding transaction; no request pipelining.

## Timing
- Reset (rstn=1 at edge): state=IDLE; wb_valid, wb_wen, wb_fp, dmem_req, dmem_we, misalign = 0; wb_rd, wb_data, dmem_addr, dmem_wdata = 0. Reset mid-transaction drops dmem_req the following cycle and returns to IDLE; no writeback issued.
- All outputs registered except ex_ready (decoded from state register).
- Non-memory op: accepted cycle N → wb_valid cycle N+1.
- Store: accepted N, dmem_req from N+1; gnt at cycle G → wb_valid at G+1. Minimum latency 2.
- Load: accepted N, req from N+1, gnt at G, rvalid at R ≥ G+1 → wb_valid at R+1. Minimum latency 3.
- wb_valid, misalign are single-cycle pulses; wb_* payload holds until next pulse.
- ex_ready is 0 from the cycle after accepting a valid memory op until the cycle after completion.

## Structure
- Shared package cpu_pkg: mem_state_t enum (IDLE, REQ, WAIT), WB_PKT width constants, REG_ADDR_W = 5.
- No sub-module: single FSM always_ff plus output register; a separate wb register module is not natural at this size.

## Test plan
- add result 0x0000_1234, rd=5 → wb_valid next cycle, wb_data=0x1234, wb_rd=5, wb_wen=1, dmem_req never asserted.
- lw addr 0x100, gnt immediate, rvalid 3 cycles later with 0xDEADBEEF → ex_ready low throughout, wb_data=0xDEADBEEF one cycle after rvalid.
- sw addr 0x200 data 0xCAFEF00D, gnt withheld 4 cycles → dmem_req/addr/wdata/we stable all 4 cycles, wb_valid with wb_wen=0 cycle after gnt.
- flw addr 0x102 → misalign=1, wb_valid=1, wb_wen=0, no dmem_req.
- lw in WAIT, rstn=1 for one cycle, stale rvalid next cycle → no wb_valid, state IDLE, ex_ready=1.
- Back-to-back: sw then add presented consecutively → add held (ex_ready=0) until store completes, then wb_valid for add one cycle after acceptance.
